// File: rtl/rand_ratio_checker.sv
// rand_ratio_checker
// Consumer/checker for a random-stimulus source. It accepts a stream of
// Bernoulli bits and bounded values, counts ones over windows of
// N = 2**WIN_LOG2 accepted samples, and judges each window against the band
// PX +/- TOL percent. It also raises a sticky flag for any accepted value
// outside [RLO, RHI].
//
// Ports
//   clock      in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   enable     in   level: 1 runs windows, 0 aborts to idle
//   in_vld     in   sample valid
//   in_rdy     out  checker ready (accept = in_vld & in_rdy)
//   in_bit     in   Bernoulli sample
//   in_val     in   range sample, VW bits
//   win_done   out  one-cycle pulse, window result valid
//   win_pass   out  last window ratio inside band (held)
//   win_fail   out  last window ratio outside band (held)
//   ones_cnt   out  ones counted in last completed window
//   range_err  out  sticky out-of-range flag for accepted in_val
//   win_total  out  completed windows since run start, saturating
//   busy       out  state is not IDLE
//
// state | meaning
// IDLE  | waiting for enable, in_rdy low, results held
// RUN   | accepting samples into the current window
// EVAL  | one cycle: compare ones*100 against the band, register result
// DONE  | one cycle: win_done high, window counters reloaded

module rand_ratio_checker #(
    parameter int PX       = 67,
    parameter int TOL      = 5,
    parameter int WIN_LOG2 = 10,
    parameter int VW       = 10,
    parameter int RLO      = 12,
    parameter int RHI      = 1000
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                enable,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic                in_bit,
    input  logic [VW-1:0]       in_val,
    output logic                win_done,
    output logic                win_pass,
    output logic                win_fail,
    output logic [WIN_LOG2:0]   ones_cnt,
    output logic                range_err,
    output logic [15:0]         win_total,
    output logic                busy
);

    localparam int N      = 2 ** WIN_LOG2;
    localparam int CW     = WIN_LOG2 + 1;
    localparam int PW     = WIN_LOG2 + 8;
    localparam int LO_PCT = (PX > TOL) ? (PX - TOL) : 0;
    localparam int HI_PCT = ((PX + TOL) > 100) ? 100 : (PX + TOL);

    localparam logic [PW-1:0] LO_B   = PW'(LO_PCT * N);
    localparam logic [PW-1:0] HI_B   = PW'(HI_PCT * N);
    localparam logic [CW-1:0] N_LOAD = CW'(N);
    localparam logic [VW-1:0] RLO_V  = VW'(RLO);
    localparam logic [VW-1:0] RHI_V  = VW'(RHI);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] acc;
    logic [CW-1:0] samp_left;   // samples still needed in this window
    logic [PW-1:0] acc_x100;
    logic          accept;
    logic          in_band;
    logic          val_bad;

    assign in_rdy   = (state == S_RUN);
    assign win_done = (state == S_DONE);
    assign busy     = (state != S_IDLE);
    assign accept   = in_vld & in_rdy;
    assign acc_x100 = PW'(acc) * PW'(100);
    assign in_band  = (acc_x100 >= LO_B) && (acc_x100 <= HI_B);
    assign val_bad  = (in_val < RLO_V) || (in_val > RHI_V);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable) state_nxt = S_RUN;
            S_RUN: begin
                if (!enable)
                    state_nxt = S_IDLE;
                else if (accept && (samp_left == CW'(1)))
                    state_nxt = S_EVAL;
            end
            S_EVAL:  state_nxt = enable ? S_DONE : S_IDLE;
            S_DONE:  state_nxt = enable ? S_RUN  : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            samp_left <= '0;
            win_pass  <= 1'b0;
            win_fail  <= 1'b0;
            ones_cnt  <= '0;
            range_err <= 1'b0;
            win_total <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        range_err <= 1'b0;
                        win_total <= '0;
                        win_pass  <= 1'b0;
                        win_fail  <= 1'b0;
                        ones_cnt  <= '0;
                        acc       <= '0;
                        samp_left <= N_LOAD;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        samp_left <= samp_left - CW'(1);
                        acc       <= acc + CW'(in_bit);
                        if (val_bad)
                            range_err <= 1'b1;
                    end
                end
                S_EVAL: begin
                    // Results are registered here so they are already valid
                    // while win_done is high; an abort in EVAL publishes nothing.
                    if (enable) begin
                        win_pass <= in_band;
                        win_fail <= ~in_band;
                        ones_cnt <= acc;
                        if (win_total != 16'hFFFF)
                            win_total <= win_total + 16'd1;
                    end
                end
                S_DONE: begin
                    acc       <= '0;
                    samp_left <= N_LOAD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_ratio_checker.sv
module tb_rand_ratio_checker;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        in_bit = 1'b0;
    logic [9:0]  in_val = 10'd500;
    logic        win_done, win_pass, win_fail, range_err, busy;
    logic [4:0]  ones_cnt;
    logic [15:0] win_total;

    rand_ratio_checker #(
        .PX(67), .TOL(5), .WIN_LOG2(4), .VW(10), .RLO(12), .RHI(1000)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .in_vld(in_vld),
        .in_rdy(in_rdy), .in_bit(in_bit), .in_val(in_val),
        .win_done(win_done), .win_pass(win_pass), .win_fail(win_fail),
        .ones_cnt(ones_cnt), .range_err(range_err), .win_total(win_total),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        bit pass;
        int ones;
        int total;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int last_cyc;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void push_exp(bit p, int ones, int total, int c);
        exp_t e;
        e.pass = p; e.ones = ones; e.total = total; e.cyc = c;
        sb.push_back(e);
    endfunction

    // Monitor: every observed win_done pops one expected window result.
    always @(negedge clock) begin
        if (!rst && win_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_win_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("win_pass", int'(win_pass), int'(e.pass));
                chk("win_fail", int'(win_fail), int'(!e.pass));
                chk("ones_cnt", int'(ones_cnt), e.ones);
                chk("win_total", int'(win_total), e.total);
                chk("done_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // One accepted sample; records the cycle of the accept edge.
    task automatic send(input bit b, input int v);
        bit done = 0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clock);
            in_vld = 1'b1;
            in_bit = b;
            in_val = 10'(v);
            if (in_rdy) begin
                last_cyc = cyc;
                done = 1;
            end
            @(posedge clock);
            #1 in_vld = 1'b0;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic send_win(input int ones, input bit exp_pass, input int exp_total);
        for (int i = 0; i < 16; i++) send(i < ones, 500);
        push_exp(exp_pass, ones, exp_total, last_cyc + 2);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int acc_n;
        int idle_n;

        // reset state
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_win_done", win_done, 0);
        chk("rst_win_pass", win_pass, 0);
        chk("rst_win_fail", win_fail, 0);
        chk("rst_ones_cnt", ones_cnt, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_win_total", win_total, 0);

        // 1: 11 ones -> 1100 inside [992,1152]
        enable = 1'b1;
        wait_cycles(1);
        chk("run_busy", busy, 1);
        chk("run_in_rdy", in_rdy, 1);
        send_win(11, 1'b1, 1);

        // 2: band edges around 992/1152
        send_win(16, 1'b0, 2);
        send_win(10, 1'b1, 3);
        send_win(9,  1'b0, 4);

        // 3: range check, 11 ones in this window
        send(1, 12);
        wait_cycles(1);
        chk("range_12", range_err, 0);
        send(1, 1000);
        wait_cycles(1);
        chk("range_1000", range_err, 0);
        send(1, 11);
        wait_cycles(1);
        chk("range_11", range_err, 1);
        send(1, 1001);
        wait_cycles(1);
        chk("range_sticky_1001", range_err, 1);
        for (int i = 4; i < 16; i++) send(i < 11, 500);
        push_exp(1'b1, 11, 5, last_cyc + 2);
        wait_cycles(3);

        // 4: in_vld held high for 40 cycles, all ones
        acc_n = 0;
        idle_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            in_vld = 1'b1;
            in_bit = 1'b1;
            in_val = 10'd500;
            if (in_rdy) begin
                acc_n++;
                if (acc_n % 16 == 0) push_exp(1'b0, 16, 5 + acc_n / 16, cyc + 2);
            end else begin
                idle_n++;
            end
        end
        @(posedge clock);
        #1 in_vld = 1'b0;
        chk("stream_accepts", acc_n, 36);
        chk("stream_rdy_low_cycles", idle_n, 4);

        // 5: abort after 8 accepts in this window (4 already in)
        for (int i = 0; i < 4; i++) send(1, 500);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_in_rdy", in_rdy, 0);
        chk("abort_hold_fail", win_fail, 1);
        chk("abort_hold_pass", win_pass, 0);
        chk("abort_hold_ones", ones_cnt, 16);
        chk("abort_hold_total", win_total, 7);
        chk("abort_hold_range", range_err, 1);
        wait_cycles(5);
        enable = 1'b1;
        wait_cycles(1);
        chk("restart_busy", busy, 1);
        chk("restart_total", win_total, 0);
        chk("restart_range", range_err, 0);
        chk("restart_fail", win_fail, 0);
        chk("restart_ones", ones_cnt, 0);
        send_win(11, 1'b1, 1);

        // 6: reset mid-window
        for (int i = 0; i < 5; i++) send(1, 500);
        @(negedge clock);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pass", win_pass, 0);
        chk("rst_mid_total", win_total, 0);
        chk("rst_mid_in_rdy", in_rdy, 0);
        @(negedge clock);
        rst = 1'b0;
        wait_cycles(1);

        // reset during DONE
        for (int i = 0; i < 16; i++) send(i < 11, 500);
        push_exp(1'b1, 11, 1, last_cyc + 2);
        wait_cycles(2);
        #1 rst = 1'b1;
        #1;
        chk("rst_done_win_done", win_done, 0);
        chk("rst_done_pass", win_pass, 0);
        chk("rst_done_total", win_total, 0);
        chk("rst_done_ones", ones_cnt, 0);
        enable = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        wait_cycles(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
